// File: rtl/hit_stat_pkg.sv
// Shared types and record layout for the hit-statistics reader.
// The record fields are defined here so every consumer decodes them the same way.
package hit_stat_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_CLR = 3'd2,
        WAIT_RDY = 3'd3,
        SEND     = 3'd4,
        CHECK    = 3'd5
    } state_t;

    localparam int SEQ_MSB = 31;
    localparam int SEQ_LSB = 24;
    localparam int TO_BIT  = 23;
    localparam int SAT_BIT = 22;
    localparam int CNT_W   = 20;

    localparam logic [CNT_W-1:0] COUNT_MAX = 20'hFFFFF;

    // Builds a record word; a saturated count is flagged so software can spot clipped windows.
    function automatic logic [31:0] pack_record(input logic [7:0] seq,
                                                input logic timed_out,
                                                input logic [CNT_W-1:0] count);
        logic [31:0] rec;
        rec                  = '0;
        rec[SEQ_MSB:SEQ_LSB] = seq;
        rec[TO_BIT]          = timed_out;
        rec[SAT_BIT]         = (count == COUNT_MAX);
        rec[CNT_W-1:0]       = count;
        return rec;
    endfunction

endpackage

// File: rtl/hit_stat_timeout.sv
// Tick counter that bounds how many window ticks a single run may take.
// It stops at the limit so the expiry level stays asserted until the next clear.
module hit_stat_timeout #(
    parameter int TIMEOUT_TICKS = 4
) (
    input  logic clk40M,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_TICKS);

    logic [7:0] tick_cnt;

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (count_en && tick && (tick_cnt != LIMIT)) begin
            tick_cnt <= tick_cnt + 8'd1;
        end
    end

    assign expired = (tick_cnt == LIMIT);

endmodule

// File: rtl/hit_stat_reader.sv
// Sequencer that starts the hit counter, collects one count per window and
// streams tagged records downstream until the run count or a stop ends the sequence.
module hit_stat_reader
    import hit_stat_pkg::*;
#(
    parameter int START_HOLD    = 2,
    parameter int TIMEOUT_TICKS = 4
) (
    input  logic        clk40M,
    input  logic        reset,
    input  logic        tick,
    input  logic        run,
    input  logic [7:0]  num_runs,
    input  logic        stop,
    output logic        stat_start,
    input  logic        stat_ready,
    input  logic [19:0] stat_count,
    output logic [31:0] rec_data,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  hold_cnt;
    logic [7:0]  runs_lat;
    logic [7:0]  sent_cnt;
    logic [7:0]  seq_num;
    logic        stop_lat;
    logic        expired;
    logic        in_run;
    logic        capture;
    logic        time_out;
    logic        finish;
    logic        launch;
    logic        accept;
    logic        tmo_clear;

    assign in_run   = (state == START) || (state == WAIT_CLR) || (state == WAIT_RDY);
    assign capture  = (state == WAIT_RDY) && stat_ready;
    // A count arriving together with the expiry still counts as a real measurement.
    assign time_out = in_run && expired && !capture;
    assign finish   = stop_lat || ((runs_lat != 8'd0) && (sent_cnt == runs_lat));
    assign launch   = (state == IDLE) && run;
    assign accept   = (state == SEND) && rec_ready;

    assign tmo_clear = launch || ((state == CHECK) && !finish);

    hit_stat_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .clk40M  (clk40M),
        .reset   (reset),
        .clear   (tmo_clear),
        .count_en(in_run),
        .tick    (tick),
        .expired (expired)
    );

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = START;
                end
            end
            START: begin
                if (time_out) begin
                    state_next = SEND;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = WAIT_CLR;
                end
            end
            // Ready left high by the previous run must fall before a new result is trusted.
            WAIT_CLR: begin
                if (time_out) begin
                    state_next = SEND;
                end else if (!stat_ready) begin
                    state_next = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (capture || time_out) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (rec_ready) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = finish ? IDLE : START;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        stat_start = (state == START);
        rec_valid  = (state == SEND);
        busy       = (state != IDLE);
        done       = (state == CHECK) && finish;
    end

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == START) begin
            hold_cnt <= hold_cnt + 4'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // A stop is only remembered here; the sequence ends at the next record boundary.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            runs_lat <= '0;
            stop_lat <= 1'b0;
        end else if (launch) begin
            runs_lat <= num_runs;
            stop_lat <= 1'b0;
        end else if ((state != IDLE) && stop) begin
            stop_lat <= 1'b1;
        end
    end

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            seq_num  <= '0;
            sent_cnt <= '0;
        end else if (launch) begin
            seq_num  <= '0;
            sent_cnt <= '0;
        end else begin
            if (accept) begin
                sent_cnt <= sent_cnt + 8'd1;
            end
            if (state == CHECK) begin
                seq_num <= seq_num + 8'd1;
            end
        end
    end

    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            rec_data <= '0;
        end else if (capture) begin
            rec_data <= pack_record(seq_num, 1'b0, stat_count);
        end else if (time_out) begin
            rec_data <= pack_record(seq_num, 1'b1, '0);
        end
    end

endmodule

// File: tb/tb_hit_stat_reader.sv
// Directed-plus-random bench for hit_stat_reader with a counter emulation and
// a sequence-level record model kept in plain variables.
module tb_hit_stat_reader;

    localparam int START_HOLD    = 2;
    localparam int TIMEOUT_TICKS = 4;

    logic        clk40M = 1'b0;
    logic        reset;
    logic        tick;
    logic        run;
    logic [7:0]  num_runs;
    logic        stop;
    logic        stat_start;
    logic        stat_ready;
    logic [19:0] stat_count;
    logic [31:0] rec_data;
    logic        rec_valid;
    logic        rec_ready;
    logic        busy;
    logic        done;

    int tests    = 0;
    int failures = 0;

    logic [7:0] mdl_seq;
    logic [7:0] mdl_sent;
    logic [7:0] mdl_n;
    bit         mdl_stop;

    hit_stat_reader #(
        .START_HOLD   (START_HOLD),
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk40M    (clk40M),
        .reset     (reset),
        .tick      (tick),
        .run       (run),
        .num_runs  (num_runs),
        .stop      (stop),
        .stat_start(stat_start),
        .stat_ready(stat_ready),
        .stat_count(stat_count),
        .rec_data  (rec_data),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk40M = ~clk40M;

    task automatic step();
        @(negedge clk40M);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Record layout: sequence byte, timeout flag, saturation flag, two zero bits, count.
    function automatic logic [31:0] expect_record(input bit timed_out, input logic [19:0] cnt);
        logic sat;
        sat = (cnt == 20'hFFFFF);
        return {mdl_seq, timed_out, sat, 2'b00, cnt};
    endfunction

    task automatic apply_stimulus(input logic [7:0] n, input bit with_stop);
        run      = 1'b1;
        num_runs = n;
        stop     = with_stop;
        step();
        run      = 1'b0;
        stop     = 1'b0;
        mdl_n    = n;
        mdl_seq  = 8'd0;
        mdl_sent = 8'd0;
        mdl_stop = 1'b0;
        check_output("busy_after_run", 32'(busy), 32'd1);
    endtask

    task automatic wait_start();
        int c;
        c = 0;
        while (!stat_start && c < 50) begin
            step();
            c++;
        end
        check_output("start_seen", 32'(stat_start), 32'd1);
    endtask

    task automatic accept_record();
        bit exp_done;
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        mdl_sent  = mdl_sent + 8'd1;
        exp_done  = mdl_stop || ((mdl_n != 8'd0) && (mdl_sent == mdl_n));
        check_output("done_pulse", 32'(done), 32'(exp_done));
        check_output("busy_in_check", 32'(busy), 32'd1);
        step();
        mdl_seq = mdl_seq + 8'd1;
        if (exp_done) begin
            check_output("idle_after_done", 32'(busy), 32'd0);
            check_output("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    // poke: 0 none, 1 stop during the wait, 2 a stray run during the wait
    task automatic serve_run(input logic [19:0] val, input int stale_hold,
                             input int rdy_delay, input int bp, input int poke);
        int n;
        int c;
        logic [31:0] exp;
        if (stale_hold > 0) begin
            stat_ready = 1'b1;
            stat_count = 20'hABCDE;
        end
        wait_start();
        n = 0;
        while (stat_start && n < 40) begin
            if (stale_hold == 0) stat_ready = 1'b0;
            n++;
            step();
        end
        check_output("start_hold", 32'(n), 32'(START_HOLD));
        for (int i = 0; i < stale_hold; i++) begin
            check_output("stale_reject", 32'(rec_valid), 32'd0);
            step();
        end
        stat_ready = 1'b0;
        for (int i = 0; i < rdy_delay; i++) begin
            if (i == 1 && poke == 1) begin
                stop     = 1'b1;
                mdl_stop = 1'b1;
            end
            if (i == 1 && poke == 2) begin
                run      = 1'b1;
                num_runs = 8'd1;
            end
            step();
            stop     = 1'b0;
            run      = 1'b0;
            num_runs = mdl_n;
            check_output("no_early_valid", 32'(rec_valid), 32'd0);
        end
        stat_count = val;
        stat_ready = 1'b1;
        exp = expect_record(1'b0, val);
        c = 0;
        while (!rec_valid && c < 10) begin
            step();
            c++;
        end
        check_output("capture_valid", 32'(rec_valid), 32'd1);
        check_output("capture_data", rec_data, exp);
        for (int i = 0; i < bp; i++) begin
            stat_count = 20'($urandom);
            step();
            check_output("hold_valid", 32'(rec_valid), 32'd1);
            check_output("hold_data", rec_data, exp);
        end
        accept_record();
    endtask

    // race=1 delivers a real count on the same cycle as the final tick.
    task automatic serve_timeout(input bit race, input logic [19:0] val);
        int ticks;
        int c;
        logic [31:0] exp;
        wait_start();
        stat_ready = 1'b0;
        ticks = 0;
        c = 0;
        while (!rec_valid && c < 40) begin
            tick = (c % 3 == 0) && (ticks < TIMEOUT_TICKS);
            if (tick) begin
                ticks++;
                if (race && ticks == TIMEOUT_TICKS) begin
                    stat_ready = 1'b1;
                    stat_count = val;
                end
            end
            step();
            tick = 1'b0;
            c++;
        end
        check_output("timeout_valid", 32'(rec_valid), 32'd1);
        check_output("timeout_ticks", 32'(ticks), 32'(TIMEOUT_TICKS));
        exp = race ? expect_record(1'b0, val) : expect_record(1'b1, 20'd0);
        check_output("timeout_data", rec_data, exp);
        accept_record();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        tick       = 1'b0;
        run        = 1'b0;
        num_runs   = 8'd0;
        stop       = 1'b0;
        stat_ready = 1'b0;
        stat_count = 20'd0;
        rec_ready  = 1'b0;
        step();
        step();
        check_output("rst_stat_start", 32'(stat_start), 32'd0);
        check_output("rst_rec_valid", 32'(rec_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_rec_data", rec_data, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("post_rst_start", 32'(stat_start), 32'd0);
        end
    endtask

    initial begin
        logic [19:0] v;
        int c;
        do_reset();

        $display("[TB] three-run sequence");
        apply_stimulus(8'd3, 1'b0);
        serve_run(20'd5, 0, 2, 0, 0);
        serve_run(20'd7, 0, 3, 2, 2);
        serve_run(20'd9, 0, 2, 0, 0);

        $display("[TB] stale ready rejection");
        apply_stimulus(8'd2, 1'b0);
        serve_run(20'($urandom), 0, 2, 0, 0);
        serve_run(20'h12345, 4, 3, 0, 0);

        $display("[TB] long backpressure");
        apply_stimulus(8'd1, 1'b0);
        serve_run(20'($urandom), 0, 2, 50, 0);

        $display("[TB] timeout");
        apply_stimulus(8'd2, 1'b0);
        serve_timeout(1'b0, 20'd0);
        serve_timeout(1'b1, 20'h00ABC);

        $display("[TB] saturation and stop with run");
        apply_stimulus(8'd2, 1'b1);
        serve_run(20'hFFFFF, 0, 2, 1, 0);
        serve_run(20'($urandom), 0, 3, 0, 0);

        $display("[TB] random sequences");
        for (int k = 0; k < 3; k++) begin
            logic [7:0] n;
            n = 8'($urandom_range(1, 4));
            apply_stimulus(n, 1'b0);
            for (int r = 0; r < int'(n); r++) begin
                serve_run(20'($urandom), 0, $urandom_range(2, 6), $urandom_range(0, 3), 0);
            end
        end

        $display("[TB] continuous mode with stop");
        apply_stimulus(8'd0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            v = 20'($urandom);
            serve_run(v, 0, 2, (i % 50 == 0) ? 1 : 0, (i == 259) ? 1 : 0);
        end

        $display("[TB] reset during send");
        apply_stimulus(8'd1, 1'b0);
        wait_start();
        stat_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        stat_count = 20'h00042;
        stat_ready = 1'b1;
        c = 0;
        while (!rec_valid && c < 10) begin
            step();
            c++;
        end
        check_output("pre_reset_valid", 32'(rec_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("async_rec_valid", 32'(rec_valid), 32'd0);
        check_output("async_busy", 32'(busy), 32'd0);
        check_output("async_rec_data", rec_data, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("no_start_after_rst", 32'(stat_start), 32'd0);
            check_output("idle_after_rst", 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
